// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : imem_fetch_arbiter
// Description : Round-robin arbiter sharing one instruction-memory read port
//               between two core fetch units. One read in flight at a time,
//               fixed memory latency, 16-bit word returned to the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Latency counter is 4 bits, so MEM_LAT must lie in 1..15.
    localparam logic [3:0] c_mem_lat = 4'(MEM_LAT);

    state_t      r_state;
    logic        r_ptr;      // core that wins when both request
    logic        r_winner;   // core owning the transaction in flight
    logic [3:0]  r_cnt;

    logic              w_any_req;
    logic              w_pick;
    logic [ADDR_W-1:0] w_pick_addr;

    // A lone requester always wins; a tie is broken by the priority pointer.
    assign w_any_req   = req0 | req1;
    assign w_pick      = (req0 & req1) ? r_ptr : req1;
    assign w_pick_addr = w_pick ? addr1 : addr0;

    // Control FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 1'b0;
            r_winner <= 1'b0;
            r_cnt    <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            mem_en   <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= '0;
            rdata    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_en  <= 1'b0;
            case (r_state)
                // RESP re-arbitrates exactly like IDLE so back-to-back
                // fetches lose no cycle beyond the response slot.
                ST_IDLE, ST_RESP: begin
                    if (w_any_req) begin
                        r_state  <= ST_ISSUE;
                        r_winner <= w_pick;
                        r_ptr    <= ~w_pick;
                        mem_addr <= w_pick_addr;
                        gnt0     <= ~w_pick;
                        gnt1     <= w_pick;
                        mem_en   <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= c_mem_lat;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Count of one marks the cycle in which memory data is valid.
                    if (r_cnt == 4'd1) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= ~r_winner;
                        rvalid1 <= r_winner;
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
